// File: rtl/dec16_pkg.sv
// Shared widths, FSM state encoding and default frame length for the
// 16-bit frame decoder.
package dec16_pkg;

   localparam int IDX_W         = 4;
   localparam int VEC_W         = 16;
   localparam int DEF_FRAME_LEN = 4;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/dec4_16.sv
// Combinational 4-to-16 one-hot decoder; the output is all-zero when z is low,
// so y is never looked at for a "no bit set" code.
module dec4_16
   import dec16_pkg::*;
(
   input  logic [IDX_W-1:0] y,
   input  logic             z,
   output logic [VEC_W-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (z) onehot[y] = 1'b1;
   end

endmodule

// File: rtl/decoder16_frame_seq.sv
// Rebuilds a 16-bit vector from a stream of {y, z} codes, one frame at a time.
// Duplicate-hit detection is compiled in only with DECODER16_DUP_CHECK_EN.
//
// state   | meaning
// COLLECT | accepting codes, OR-ing each decoded bit into the accumulator
// HOLD    | frame closed, w/out_valid presented until out_ready
module decoder16_frame_seq
   import dec16_pkg::*;
#(
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] y,
   input  logic             z,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [VEC_W-1:0] w,
   output logic [CNT_W-1:0] code_cnt,
   output logic             dup
);

   state_t           state, state_nxt;
   logic [VEC_W-1:0] acc;
   logic [VEC_W-1:0] onehot;
   logic [CNT_W-1:0] cnt_plus1;
   logic             accept;
   logic             close;

   dec4_16 u_dec (
      .y      (y),
      .z      (z),
      .onehot (onehot)
   );

   // accept is derived from state directly so it does not loop through in_ready
   assign accept    = in_valid && (state == COLLECT);
   assign cnt_plus1 = code_cnt + 1'b1;
   assign close     = accept && (in_last || (cnt_plus1 == CNT_W'(FRAME_LEN)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            if (close) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         w        <= '0;
         code_cnt <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  acc      <= acc | onehot;
                  code_cnt <= cnt_plus1;
                  if (close) w <= acc | onehot;
               end
            end
            HOLD: begin
               // w is left as-is so the last frame stays visible
               if (out_ready) begin
                  acc      <= '0;
                  code_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DECODER16_DUP_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dup <= 1'b0;
      end else begin
         case (state)
            COLLECT: if (accept && |(acc & onehot)) dup <= 1'b1;
            HOLD:    if (out_ready) dup <= 1'b0;
            default: ;
         endcase
      end
   end
`else
   assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_decoder16_frame_seq.sv
// Directed bench for decoder16_frame_seq: a frame-level model (list of accepted
// indices) is compared every cycle, plus literal expectations for each scenario.
module tb_decoder16_frame_seq;

   localparam int FRAME_LEN = 4;
   localparam int CNT_W     = 5;
`ifdef DECODER16_DUP_CHECK_EN
   localparam bit DUP_EN = 1'b1;
`else
   localparam bit DUP_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       y = 4'd0;
   logic             z = 1'b0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [15:0]      w;
   logic [CNT_W-1:0] code_cnt;
   logic             dup;

   int checks = 0;
   int errors = 0;

   decoder16_frame_seq #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .z         (z),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .w         (w),
      .code_cnt  (code_cnt),
      .dup       (dup)
   );

   always #5 clk = ~clk;

   // Frame model: the set bits of a frame are just the list of z=1 indices seen.
   logic [3:0]  m_idx[$];
   int          m_cnt  = 0;
   bit          m_hold = 1'b0;
   logic [15:0] m_w    = 16'h0000;

   function automatic bit has_dup();
      for (int i = 0; i < m_idx.size(); i++)
         for (int j = i + 1; j < m_idx.size(); j++)
            if (m_idx[i] == m_idx[j]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idx.delete();
         m_cnt  = 0;
         m_hold = 1'b0;
         m_w    = 16'h0000;
      end else if (!m_hold) begin
         if (in_valid) begin
            if (z) m_idx.push_back(y);
            m_cnt++;
            if (in_last || m_cnt == FRAME_LEN) begin
               m_hold = 1'b1;
               m_w    = 16'h0000;
               foreach (m_idx[i]) m_w = m_w | (16'h0001 << m_idx[i]);
            end
         end
      end else if (out_ready) begin
         m_hold = 1'b0;
         m_idx.delete();
         m_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("model_out_valid", 32'(out_valid), 32'(m_hold));
         check("model_in_ready", 32'(in_ready), 32'(!m_hold));
         check("model_w", 32'(w), 32'(m_w));
         check("model_code_cnt", 32'(code_cnt), 32'(m_cnt));
         check("model_dup", 32'(dup), 32'(DUP_EN && has_dup()));
      end
   end

   // Inputs are set at a falling edge and held through the following rising edge.
   task automatic send(input logic [3:0] yi, input logic zi, input logic last);
      in_valid = 1'b1;
      y        = yi;
      z        = zi;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_frame();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   function automatic logic [4:0] encode(input logic [15:0] v);
      for (int i = 15; i >= 0; i--)
         if (v[i]) return {4'(i), 1'b1};
      return 5'b0;
   endfunction

   initial begin
      logic [4:0] enc;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_w", 32'(w), 32'h0);
      check("rst_code_cnt", 32'(code_cnt), 32'd0);
      check("rst_dup", 32'(dup), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full frame, automatic close on the 4th code
      send(4'd3, 1'b1, 1'b0);
      send(4'd7, 1'b1, 1'b0);
      send(4'd0, 1'b0, 1'b0);
      check("f1_not_closed_early", 32'(out_valid), 32'd0);
      send(4'd15, 1'b1, 1'b0);
      check("f1_out_valid", 32'(out_valid), 32'd1);
      check("f1_w", 32'(w), 32'h8088);
      check("f1_code_cnt", 32'(code_cnt), 32'd4);
      check("f1_dup", 32'(dup), 32'd0);
      release_frame();
      check("f1_back_collect", 32'(in_ready), 32'd1);
      check("f1_cnt_cleared", 32'(code_cnt), 32'd0);

      // All z=0 frame with unknown y
      for (int i = 0; i < FRAME_LEN; i++) send(4'bxxxx, 1'b0, 1'b0);
      check("zero_out_valid", 32'(out_valid), 32'd1);
      check("zero_w", 32'(w), 32'h0);
      check("zero_w_known", 32'($isunknown(w)), 32'd0);
      release_frame();

      // Duplicate code, early close via in_last
      send(4'd5, 1'b1, 1'b0);
      send(4'd5, 1'b1, 1'b1);
      check("dup_w", 32'(w), 32'h0020);
      check("dup_code_cnt", 32'(code_cnt), 32'd2);
      check("dup_flag", 32'(dup), 32'(DUP_EN));

      // Back-pressure: HOLD must ignore in_valid while out_ready is low
      in_valid = 1'b1; y = 4'd4; z = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_w", 32'(w), 32'h0020);
         check("stall_code_cnt", 32'(code_cnt), 32'd2);
      end
      in_valid = 1'b0;
      release_frame();
      check("stall_release_ready", 32'(in_ready), 32'd1);
      check("stall_release_cnt", 32'(code_cnt), 32'd0);
      check("stall_release_dup", 32'(dup), 32'd0);
      check("w_kept_after_release", 32'(w), 32'h0020);

      // Reset mid-frame
      send(4'd2, 1'b1, 1'b0);
      send(4'd9, 1'b1, 1'b0);
      check("pre_rst_cnt", 32'(code_cnt), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_w", 32'(w), 32'h0);
      check("mid_rst_cnt", 32'(code_cnt), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(4'd1, 1'b1, 1'b1);
      check("post_rst_w", 32'(w), 32'h0002);
      check("post_rst_cnt", 32'(code_cnt), 32'd1);
      release_frame();

      // in_last on the code that also reaches FRAME_LEN: one close only
      send(4'd8, 1'b1, 1'b0);
      send(4'd9, 1'b1, 1'b0);
      send(4'd10, 1'b1, 1'b0);
      send(4'd11, 1'b1, 1'b1);
      check("last_at_len_w", 32'(w), 32'h0F00);
      check("last_at_len_cnt", 32'(code_cnt), 32'd4);
      release_frame();
      @(negedge clk);
      check("last_at_len_single", 32'(out_valid), 32'd0);

      // Encoder round trip
      enc = encode(16'h0400);
      send(enc[4:1], enc[0], 1'b1);
      check("roundtrip_w", 32'(w), 32'h0400);
      release_frame();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, limit %0d ns", 100000);
      $fatal(1);
   end

endmodule
